// File: rtl/qft_phase_sched.sv
// Phase-rotation scheduler: streams N buffered complex amplitudes through a shared
// complex multiplier, pairing amplitude idx with twiddle (idx * step) mod N.
module qft_phase_sched #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_valid,
  input  logic [AW-1:0] load_idx,
  input  logic [7:0]    load_r,
  input  logic [7:0]    load_i,
  input  logic          start,
  input  logic [AW-1:0] phase_step,
  output logic [AW-1:0] tw_addr,
  input  logic [11:0]   tw_cos,
  input  logic [11:0]   tw_sin,
  output logic [7:0]    mul_in_r,
  output logic [7:0]    mul_in_i,
  output logic [11:0]   mul_cos,
  output logic [11:0]   mul_sin,
  input  logic [12:0]   mul_out_r,
  input  logic [12:0]   mul_out_i,
  output logic          busy,
  output logic          res_valid,
  output logic [AW-1:0] res_idx,
  output logic [12:0]   res_r,
  output logic [12:0]   res_i,
  output logic          done
);

  localparam int N = 1 << AW;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_MUL   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [AW-1:0]   idx_r;
  logic [AW-1:0]   step_r;
  logic [AW-1:0]   idx_inc_s;
  logic [2*AW-1:0] prod_s;
  logic            last_s;
  logic            accept_s;
  logic            write_s;

  logic [7:0]      amp_re_r [N];
  logic [7:0]      amp_im_r [N];

  logic            busy_r;
  logic            done_r;
  logic            res_valid_r;
  logic [AW-1:0]   res_idx_r;
  logic [12:0]     res_r_r;
  logic [12:0]     res_i_r;

  // The buffer only accepts writes while idle, so a pass always sees a frozen snapshot.
  assign accept_s  = (state_r == ST_IDLE) && start;
  assign write_s   = (state_r == ST_IDLE) && load_valid;
  assign last_s    = (idx_r == {AW{1'b1}});
  assign idx_inc_s = idx_r + {{(AW-1){1'b0}}, 1'b1};
  assign prod_s    = {{AW{1'b0}}, idx_r} * {{AW{1'b0}}, step_r};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: state_s = ST_MUL;
      ST_MUL: begin
        if (last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // ROM address and multiplier operands, driven only in their own phase
  always_comb begin
    tw_addr  = {AW{1'b0}};
    mul_in_r = 8'd0;
    mul_in_i = 8'd0;
    mul_cos  = 12'd0;
    mul_sin  = 12'd0;
    case (state_r)
      ST_FETCH: begin
        tw_addr = prod_s[AW-1:0];
      end
      ST_MUL: begin
        mul_in_r = amp_re_r[idx_r];
        mul_in_i = amp_im_r[idx_r];
        mul_cos  = tw_cos;
        mul_sin  = tw_sin;
      end
      ST_IDLE: begin
        tw_addr = {AW{1'b0}};
      end
      ST_DONE: begin
        tw_addr = {AW{1'b0}};
      end
      default: begin
        tw_addr = {AW{1'b0}};
      end
    endcase
  end

  // Element counter and latched rotation step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r  <= {AW{1'b0}};
      step_r <= {AW{1'b0}};
    end else if (accept_s) begin
      idx_r  <= {AW{1'b0}};
      step_r <= phase_step;
    end else if ((state_r == ST_MUL) && !last_s) begin
      idx_r  <= idx_inc_s;
    end
  end

  // Amplitude buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        amp_re_r[i] <= 8'd0;
        amp_im_r[i] <= 8'd0;
      end
    end else if (write_s) begin
      amp_re_r[load_idx] <= load_r;
      amp_im_r[load_idx] <= load_i;
    end
  end

  // Result capture; the product is passed through untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_r <= 1'b0;
      res_idx_r   <= {AW{1'b0}};
      res_r_r     <= 13'd0;
      res_i_r     <= 13'd0;
    end else begin
      res_valid_r <= (state_r == ST_MUL);
      if (state_r == ST_MUL) begin
        res_idx_r <= idx_r;
        res_r_r   <= mul_out_r;
        res_i_r   <= mul_out_i;
      end
    end
  end

  // Status flags registered from the next state so they line up with the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s != ST_IDLE);
      done_r <= (state_s == ST_DONE);
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign res_valid = res_valid_r;
  assign res_idx   = res_idx_r;
  assign res_r     = res_r_r;
  assign res_i     = res_i_r;

endmodule

// File: tb/tb_qft_phase_sched.sv
// Self-checking bench for qft_phase_sched: directed vector table, corner sequences
// and randomized passes checked against a cycle-level model of the pass schedule.
module tb_qft_phase_sched;

  localparam int AW = 3;
  localparam int N  = 8;

  logic        clk, rst_n, load_valid, start;
  logic [2:0]  load_idx, phase_step, tw_addr, res_idx;
  logic [7:0]  load_r, load_i, mul_in_r, mul_in_i;
  logic [11:0] tw_cos, tw_sin, mul_cos, mul_sin;
  logic [12:0] mul_out_r, mul_out_i, res_r, res_i;
  logic        busy, res_valid, done;

  int total, bad;
  int rom_c [N];
  int rom_s [N];
  int mdl_r [N];
  int mdl_i [N];
  int wrap_seq [N];
  logic [12:0] got_r [N];
  logic [12:0] got_i [N];
  logic [2:0]  got_tw [N];

  typedef struct {
    int lidx; int lr; int li; int step; bit same;
    int exp_tw; int exp_r; int exp_i;
  } vec_t;
  vec_t vt [5];

  qft_phase_sched #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_idx(load_idx),
    .load_r(load_r), .load_i(load_i), .start(start), .phase_step(phase_step),
    .tw_addr(tw_addr), .tw_cos(tw_cos), .tw_sin(tw_sin),
    .mul_in_r(mul_in_r), .mul_in_i(mul_in_i), .mul_cos(mul_cos), .mul_sin(mul_sin),
    .mul_out_r(mul_out_r), .mul_out_i(mul_out_i), .busy(busy), .res_valid(res_valid),
    .res_idx(res_idx), .res_r(res_r), .res_i(res_i), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Complex product of an integer amplitude and a Q1.10 twiddle, kept to 5 fraction bits
  function automatic logic [12:0] cmul(input int ar, input int ai, input int c, input int s,
                                       input bit imag);
    int p;
    if (imag) p = ar * s + ai * c;
    else      p = ar * c - ai * s;
    return 13'(p >>> 5);
  endfunction

  // Twiddle ROM with one cycle of read latency
  always @(posedge clk) begin
    tw_cos <= 12'(rom_c[tw_addr]);
    tw_sin <= 12'(rom_s[tw_addr]);
  end

  // Shared combinational multiplier
  always_comb begin
    mul_out_r = cmul($signed(mul_in_r), $signed(mul_in_i), $signed(mul_cos), $signed(mul_sin), 1'b0);
    mul_out_i = cmul($signed(mul_in_r), $signed(mul_in_i), $signed(mul_cos), $signed(mul_sin), 1'b1);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".res_idx"}, 32'(res_idx), 32'd0);
    chk({tag, ".res_r"}, 32'(res_r), 32'd0);
    chk({tag, ".res_i"}, 32'(res_i), 32'd0);
    chk({tag, ".tw_addr"}, 32'(tw_addr), 32'd0);
    chk({tag, ".mul_in"}, 32'({mul_in_r, mul_in_i}), 32'd0);
    chk({tag, ".mul_cs"}, 32'({mul_cos, mul_sin}), 32'd0);
  endtask

  // Called at a falling edge; returns at a falling edge
  task automatic load(input int idx, input int r, input int i);
    load_valid = 1'b1; load_idx = 3'(idx); load_r = 8'(r); load_i = 8'(i);
    @(posedge clk);
    mdl_r[idx] = r; mdl_i[idx] = i;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  // One pass, checked cycle by cycle from E0 (the start edge) to three cycles past done
  task automatic run_pass(input int k, input int inject, input int abort,
                          input bit do_load, input int lidx, input int lr, input int li);
    int nres, ndone, n, a;
    logic [2:0]  e_tw;
    logic [7:0]  e_ar, e_ai;
    logic [11:0] e_c, e_s;
    start = 1'b1; phase_step = 3'(k);
    if (do_load) begin
      load_valid = 1'b1; load_idx = 3'(lidx); load_r = 8'(lr); load_i = 8'(li);
    end
    @(posedge clk);
    if (do_load) begin mdl_r[lidx] = lr; mdl_i[lidx] = li; end
    nres = 0; ndone = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) @(posedge clk);
      @(negedge clk);
      start = 1'b0; load_valid = 1'b0; phase_step = 3'($urandom);
      chk($sformatf("busy c%0d", c), 32'(busy), 32'(c <= 17));
      e_tw = 3'd0;
      if ((c % 2 == 1) && c <= 15) begin
        e_tw = 3'((((c - 1) / 2) * k) % N);
        got_tw[(c - 1) / 2] = tw_addr;
      end
      chk($sformatf("tw_addr c%0d", c), 32'(tw_addr), 32'(e_tw));
      e_ar = 8'd0; e_ai = 8'd0; e_c = 12'd0; e_s = 12'd0;
      if ((c % 2 == 0) && c <= 16) begin
        n = (c - 2) / 2; a = (n * k) % N;
        e_ar = 8'(mdl_r[n]); e_ai = 8'(mdl_i[n]);
        e_c = 12'(rom_c[a]); e_s = 12'(rom_s[a]);
      end
      chk($sformatf("mul_in c%0d", c), 32'({mul_in_r, mul_in_i}), 32'({e_ar, e_ai}));
      chk($sformatf("mul_cs c%0d", c), 32'({mul_cos, mul_sin}), 32'({e_c, e_s}));
      chk($sformatf("res_valid c%0d", c), 32'(res_valid),
          32'((c % 2 == 1) && c >= 3 && c <= 17));
      if ((c % 2 == 1) && c >= 3 && c <= 17) begin
        n = (c - 3) / 2; a = (n * k) % N;
        got_r[n] = res_r; got_i[n] = res_i;
        chk($sformatf("res_idx c%0d", c), 32'(res_idx), 32'(n));
        chk($sformatf("res_r n%0d", n), 32'(res_r),
            32'(cmul(mdl_r[n], mdl_i[n], rom_c[a], rom_s[a], 1'b0)));
        chk($sformatf("res_i n%0d", n), 32'(res_i),
            32'(cmul(mdl_r[n], mdl_i[n], rom_c[a], rom_s[a], 1'b1)));
      end
      chk($sformatf("done c%0d", c), 32'(done), 32'(c == 17));
      nres += int'(res_valid);
      ndone += int'(done);
      if (c == inject) begin
        start = 1'b1; load_valid = 1'b1; load_idx = 3'd0; load_r = 8'd99; load_i = 8'd99;
      end
      if (c == abort) begin
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("abort");
        for (int j = 0; j < N; j++) begin mdl_r[j] = 0; mdl_i[j] = 0; end
        return;
      end
    end
    chk("res_valid count", 32'(nres), 32'd8);
    chk("done count", 32'(ndone), 32'd1);
  endtask

  initial begin
    logic [12:0] e13;
    total = 0; bad = 0;
    rom_c = '{1024, 724, 0, -724, -1024, -724, 0, 724};
    rom_s = '{0, 724, 1024, 724, 0, -724, -1024, -724};
    wrap_seq = '{0, 3, 6, 1, 4, 7, 2, 5};
    for (int j = 0; j < N; j++) begin mdl_r[j] = 0; mdl_i[j] = 0; end
    // lidx, lr, li, step, same-cycle, expected tw_addr / res_r / res_i at lidx
    vt[0] = '{2,    5,   -3, 0, 1'b0, 0,  160,  -96};
    vt[1] = '{1,   10,    0, 2, 1'b0, 2,    0,  320};
    vt[2] = '{0,    7,    0, 0, 1'b1, 0,  224,    0};
    vt[3] = '{3,   -4,    2, 3, 1'b0, 1, -136,  -46};
    vt[4] = '{7,  127, -128, 5, 1'b0, 3,   22, 5769};

    rst_n = 1'b0; load_valid = 1'b0; start = 1'b0;
    load_idx = 3'd0; load_r = 8'd0; load_i = 8'd0; phase_step = 3'd0;
    #2;
    chk_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[v]) begin
      if (!vt[v].same) load(vt[v].lidx, vt[v].lr, vt[v].li);
      run_pass(vt[v].step, 0, 0, vt[v].same, vt[v].lidx, vt[v].lr, vt[v].li);
      chk($sformatf("vec%0d tw", v), 32'(got_tw[vt[v].lidx]), 32'(vt[v].exp_tw));
      e13 = 13'(vt[v].exp_r);
      chk($sformatf("vec%0d res_r", v), 32'(got_r[vt[v].lidx]), 32'(e13));
      e13 = 13'(vt[v].exp_i);
      chk($sformatf("vec%0d res_i", v), 32'(got_i[vt[v].lidx]), 32'(e13));
    end

    run_pass(3, 0, 0, 1'b0, 0, 0, 0);
    for (int j = 0; j < N; j++) chk($sformatf("wrap%0d", j), 32'(got_tw[j]), 32'(wrap_seq[j]));

    run_pass(1, 5, 0, 1'b0, 0, 0, 0);
    run_pass(0, 0, 0, 1'b0, 0, 0, 0);
    chk("guard buf0_r", 32'(got_r[0]), 32'(cmul(mdl_r[0], mdl_i[0], 1024, 0, 1'b0)));

    for (int p = 0; p < 6; p++) begin
      for (int j = 0; j < 3; j++)
        load(int'($urandom_range(7)), int'($urandom_range(255)) - 128,
             int'($urandom_range(255)) - 128);
      run_pass(int'($urandom_range(7)), 0, 0, 1'b0, 0, 0, 0);
    end

    for (int j = 0; j < N; j++) load(j, j + 1, -(j + 2));
    run_pass(5, 0, 8, 1'b0, 0, 0, 0);
    repeat (2) begin
      @(negedge clk);
      chk_zero_outputs("held");
    end
    rst_n = 1'b1;
    run_pass(2, 0, 0, 1'b0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
